apb_select_handshake: RTL and testbench

- Synthesizable single-clock model of an APB-style select/enable/ready handshake.
- Contains one master-side requester FSM, NO_OF_SLAVES responder FSMs (one 32-bit register each) and the one-hot select/ready routing between them.
- Sits between a local command source and the slave fabric.
- Replaces a behavioural master/slave driver pair, so transfer timing is defined cycle-exactly.

---
 rtl/apb_select_handshake_pkg.sv | 20 ++
 rtl/apb_select_handshake_if.sv | 33 +++
 rtl/apb_select_handshake_responder.sv | 54 +++++
 rtl/apb_select_handshake.sv | 143 ++++++++++++++
 tb/tb_apb_select_handshake.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_select_handshake_pkg.sv
// Shared types and defaults for the APB select/enable/ready handshake slice.
// Optional feature macro used by the top: APB_LINK_TIMEOUT_EN.
package apb_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned DEF_NO_OF_SLAVES = 1;
  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DEFAULT_TIMEOUT  = 50;

  // Index width for slave selection; a single slave still gets a 1-bit field.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_select_handshake_if.sv
// Command/response and observed APB signals of apb_select_handshake.
// The DUT connects through the slave modport; a command source uses master.
interface apb_select_handshake_if
  import apb_link_pkg::*;
#(
  parameter int unsigned NO_OF_SLAVES = DEF_NO_OF_SLAVES,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH
);
  localparam int unsigned SEL_W = sel_width(NO_OF_SLAVES);

  logic                    req_valid;
  logic                    req_ready;
  logic [SEL_W-1:0]        req_slave;
  logic                    req_write;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;
  logic [NO_OF_SLAVES-1:0] pselx;
  logic                    penable;
  logic                    pready;

  modport master (
    output req_valid, req_slave, req_write, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, pselx, penable, pready
  );

  modport slave (
    input  req_valid, req_slave, req_write, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, pselx, penable, pready
  );

endinterface

// File: rtl/apb_select_handshake_responder.sv
// One APB responder: wait counter, registered pready and a single data register.
module apb_slave_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SLAVE_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic                  i_pwrite,
  input  logic [DATA_WIDTH-1:0] i_pwdata,
  output logic                  o_pready,
  output logic [DATA_WIDTH-1:0] o_prdata
);

  logic [3:0]            r_cnt;
  logic                  r_pready;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_complete;

  assign w_complete = i_psel & i_penable & r_pready;

  // pready rises SLAVE_WAIT+1 edges after psel is first sampled; losing psel restarts the wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_pready <= 1'b0;
    end else if (!i_psel) begin
      r_cnt    <= '0;
      r_pready <= 1'b0;
    end else if (r_pready) begin
      if (i_penable) begin
        r_cnt    <= '0;
        r_pready <= 1'b0;
      end
    end else if (r_cnt == 4'(SLAVE_WAIT)) begin
      r_pready <= 1'b1;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (w_complete && i_pwrite) begin
      r_data <= i_pwdata;
    end
  end

  assign o_pready = r_pready;
  assign o_prdata = r_data;

endmodule

// File: rtl/apb_select_handshake.sv
// APB-style requester FSM plus NO_OF_SLAVES responders and one-hot select/ready routing.
// Define APB_LINK_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES without pready.
module apb_select_handshake
  import apb_link_pkg::*;
#(
  parameter int unsigned NO_OF_SLAVES = DEF_NO_OF_SLAVES,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned SLAVE_WAIT   = 1
`ifdef APB_LINK_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
`endif
) (
  input logic                  clk,
  input logic                  rst_n,
  apb_select_handshake_if.slave bus
);

  localparam int unsigned SEL_W = sel_width(NO_OF_SLAVES);

  apb_state_e              r_state;
  apb_state_e              w_state_nxt;
  logic [SEL_W-1:0]        r_slave;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;
  logic [NO_OF_SLAVES-1:0] w_pselx;
  logic [NO_OF_SLAVES-1:0] w_pready_vec;
  logic [DATA_WIDTH-1:0]   w_prdata [NO_OF_SLAVES];
  logic [DATA_WIDTH-1:0]   w_prdata_sel;
  logic                    w_penable;
  logic                    w_pready;
  logic                    w_accept;
  logic                    w_done;
  logic                    w_timeout;

  // An out-of-range index decodes to no select at all.
  always_comb begin
    w_pselx = '0;
    for (int unsigned i = 0; i < NO_OF_SLAVES; i++) begin
      w_pselx[i] = (r_state != IDLE) && (r_slave == SEL_W'(i));
    end
  end

  always_comb begin
    w_prdata_sel = '0;
    for (int unsigned i = 0; i < NO_OF_SLAVES; i++) begin
      if (w_pselx[i]) w_prdata_sel = w_prdata[i];
    end
  end

  assign w_penable = (r_state == ACCESS);
  assign w_pready  = $onehot(w_pselx) && |(w_pselx & w_pready_vec);

`ifdef APB_LINK_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_to_cnt <= '0;
    else if (r_state == ACCESS)  r_to_cnt <= r_to_cnt + TO_W'(1);
    else                         r_to_cnt <= '0;
  end

  assign w_timeout = (r_state == ACCESS) && !w_pready &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP:  w_state_nxt = ACCESS;
      ACCESS: begin
        if (w_pready || w_timeout) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_slave     <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= w_done;
      if (w_accept) begin
        r_slave <= bus.req_slave;
        r_write <= bus.req_write;
        r_wdata <= bus.req_wdata;
      end
      if (w_done) begin
        r_rsp_rdata <= (r_write || w_timeout) ? '0 : w_prdata_sel;
        r_rsp_err   <= w_timeout;
      end
    end
  end

  for (genvar g = 0; g < NO_OF_SLAVES; g++) begin : g_slave
    apb_slave_responder #(
      .DATA_WIDTH (DATA_WIDTH),
      .SLAVE_WAIT (SLAVE_WAIT)
    ) u_slave (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_psel    (w_pselx[g]),
      .i_penable (w_penable),
      .i_pwrite  (r_write),
      .i_pwdata  (r_wdata),
      .o_pready  (w_pready_vec[g]),
      .o_prdata  (w_prdata[g])
    );
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.pselx     = w_pselx;
  assign bus.penable   = w_penable;
  assign bus.pready    = w_pready;

endmodule

// File: tb/tb_apb_select_handshake.sv
// Bench for apb_select_handshake: dut0 (1 slave, wait 1) and dut1 (2 slaves, wait 0)
// checked every cycle against a transfer-level model plus pinned literal expectations.
module tb_apb_select_handshake;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_select_handshake_if #(.NO_OF_SLAVES(1), .DATA_WIDTH(32)) if0 ();
  apb_select_handshake_if #(.NO_OF_SLAVES(2), .DATA_WIDTH(32)) if1 ();

  apb_select_handshake #(.NO_OF_SLAVES(1), .DATA_WIDTH(32), .SLAVE_WAIT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  apb_select_handshake #(.NO_OF_SLAVES(2), .DATA_WIDTH(32), .SLAVE_WAIT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  logic        t_valid [2];
  logic        t_slave [2];
  logic        t_write [2];
  logic [31:0] t_wdata [2];

  assign if0.req_valid = t_valid[0];
  assign if0.req_slave = t_slave[0];
  assign if0.req_write = t_write[0];
  assign if0.req_wdata = t_wdata[0];
  assign if1.req_valid = t_valid[1];
  assign if1.req_slave = t_slave[1];
  assign if1.req_write = t_write[1];
  assign if1.req_wdata = t_wdata[1];

  logic        o_ready [2];
  logic        o_rv    [2];
  logic        o_err   [2];
  logic        o_pen   [2];
  logic        o_prdy  [2];
  logic [1:0]  o_psel  [2];
  logic [31:0] o_rd    [2];

  assign o_ready[0] = if0.req_ready;  assign o_ready[1] = if1.req_ready;
  assign o_rv[0]    = if0.rsp_valid;  assign o_rv[1]    = if1.rsp_valid;
  assign o_err[0]   = if0.rsp_err;    assign o_err[1]   = if1.rsp_err;
  assign o_pen[0]   = if0.penable;    assign o_pen[1]   = if1.penable;
  assign o_prdy[0]  = if0.pready;     assign o_prdy[1]  = if1.pready;
  assign o_psel[0]  = {1'b0, if0.pselx};
  assign o_psel[1]  = if1.pselx;
  assign o_rd[0]    = if0.rsp_rdata;  assign o_rd[1]    = if1.rsp_rdata;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Transfer-level model: m_t numbers the cycles of a transfer (1 = select phase).
  int          NSL [2] = '{1, 2};
  int          WT  [2] = '{1, 0};
  logic        m_busy [2];
  int          m_t    [2];
  int          m_s    [2];
  logic        m_wr   [2];
  logic [31:0] m_wd   [2];
  logic        m_rv   [2];
  logic [31:0] m_rd   [2];
  logic [31:0] m_mem  [2][2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_busy[d]   <= 1'b0;
        m_t[d]      <= 0;
        m_s[d]      <= 0;
        m_wr[d]     <= 1'b0;
        m_wd[d]     <= '0;
        m_rv[d]     <= 1'b0;
        m_rd[d]     <= '0;
        m_mem[d][0] <= '0;
        m_mem[d][1] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_rv[d] <= 1'b0;
        if (!m_busy[d]) begin
          if (t_valid[d]) begin
            m_busy[d] <= 1'b1;
            m_t[d]    <= 1;
            m_s[d]    <= int'(t_slave[d]);
            m_wr[d]   <= t_write[d];
            m_wd[d]   <= t_wdata[d];
          end
        end else if (m_s[d] < NSL[d] && m_t[d] == 2 + WT[d]) begin
          m_busy[d] <= 1'b0;
          m_rv[d]   <= 1'b1;
          if (m_wr[d]) begin
            m_mem[d][m_s[d]] <= m_wd[d];
            m_rd[d]          <= '0;
          end else begin
            m_rd[d] <= m_mem[d][m_s[d]];
          end
        end else begin
          m_t[d] <= m_t[d] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic       sel_ok;
      logic [1:0] e_psel;
      sel_ok = m_busy[d] && (m_s[d] < NSL[d]);
      e_psel = sel_ok ? (2'b01 << m_s[d]) : 2'b00;
      chk($sformatf("dut%0d req_ready", d), 32'(o_ready[d]), 32'(!m_busy[d]));
      chk($sformatf("dut%0d pselx", d),     32'(o_psel[d]),  32'(e_psel));
      chk($sformatf("dut%0d penable", d),   32'(o_pen[d]),   32'(m_busy[d] && m_t[d] >= 2));
      chk($sformatf("dut%0d pready", d),    32'(o_prdy[d]),  32'(sel_ok && m_t[d] == 2 + WT[d]));
      chk($sformatf("dut%0d rsp_valid", d), 32'(o_rv[d]),    32'(m_rv[d]));
      chk($sformatf("dut%0d rsp_err", d),   32'(o_err[d]),   32'd0);
      if (m_rv[d]) chk($sformatf("dut%0d rsp_rdata", d), o_rd[d], m_rd[d]);
    end
  end

  task automatic issue(input int d, input logic s, input logic wr, input logic [31:0] wd);
    t_valid[d] = 1'b1;
    t_slave[d] = s;
    t_write[d] = wr;
    t_wdata[d] = wd;
    @(posedge clk);
    #2;
    t_valid[d] = 1'b0;
  endtask

  task automatic wait_rsp(input int d, input string nm, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    repeat (40) begin
      if (!found) begin
        @(negedge clk);
        n++;
        if (o_rv[d]) found = 1'b1;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: no rsp_valid within 40 cycles, required one", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      t_valid[d] = 1'b0;
      t_slave[d] = 1'b0;
      t_write[d] = 1'b0;
      t_wdata[d] = '0;
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset req_ready", 32'(o_ready[0]), 32'd1);
    chk("reset pselx",     32'(o_psel[0]),  32'd0);
    chk("reset rsp_rdata", o_rd[0],         32'd0);

    // Write slave 0, cycle-exact phases
    t_valid[0] = 1'b1; t_slave[0] = 1'b0; t_write[0] = 1'b1; t_wdata[0] = 32'hA5A5_0001;
    @(posedge clk); #2 t_valid[0] = 1'b0;
    @(negedge clk);
    chk("wr setup pselx",    32'(o_psel[0]), 32'd1);
    chk("wr setup penable",  32'(o_pen[0]),  32'd0);
    @(negedge clk);
    chk("wr access penable", 32'(o_pen[0]),  32'd1);
    chk("wr access pready0", 32'(o_prdy[0]), 32'd0);
    @(negedge clk);
    chk("wr access pready1", 32'(o_prdy[0]), 32'd1);
    @(negedge clk);
    chk("wr done rsp_valid", 32'(o_rv[0]),   32'd1);
    chk("wr done pselx",     32'(o_psel[0]), 32'd0);
    chk("wr done penable",   32'(o_pen[0]),  32'd0);
    chk("wr done rsp_err",   32'(o_err[0]),  32'd0);

    // Read back slave 0
    issue(0, 1'b0, 1'b0, 32'h0);
    wait_rsp(0, "rd0", n);
    chk("rd0 rdata",   o_rd[0], 32'hA5A5_0001);
    chk("rd0 latency", 32'(n),  32'd4);

    // Back-to-back write then read with req_valid held
    t_valid[0] = 1'b1; t_slave[0] = 1'b0; t_write[0] = 1'b1; t_wdata[0] = 32'h1234_5678;
    @(posedge clk); #2 t_write[0] = 1'b0;
    wait_rsp(0, "b2b wr", n);
    chk("b2b ready at rsp", 32'(o_ready[0]), 32'd1);
    @(posedge clk); #2 t_valid[0] = 1'b0;
    @(negedge clk);
    chk("b2b 2nd setup pselx",   32'(o_psel[0]), 32'd1);
    chk("b2b 2nd setup penable", 32'(o_pen[0]),  32'd0);
    wait_rsp(0, "b2b rd", n);
    chk("b2b rd rdata", o_rd[0], 32'h1234_5678);

    // Asynchronous reset during ACCESS
    issue(0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst pselx",     32'(o_psel[0]), 32'd0);
    chk("arst penable",   32'(o_pen[0]),  32'd0);
    chk("arst pready",    32'(o_prdy[0]), 32'd0);
    chk("arst rsp_valid", 32'(o_rv[0]),   32'd0);
    chk("arst rsp_rdata", o_rd[0],        32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    issue(0, 1'b0, 1'b0, 32'h0);
    wait_rsp(0, "post-rst rd", n);
    chk("post-rst rdata", o_rd[0], 32'h0);
    issue(0, 1'b0, 1'b1, 32'h0BAD_F00D);
    wait_rsp(0, "post-rst wr", n);
    issue(0, 1'b0, 1'b0, 32'h0);
    wait_rsp(0, "post-rst rd2", n);
    chk("post-rst rdata2", o_rd[0], 32'h0BAD_F00D);

    // Out-of-range slave: accepted, never selected, never completes
    issue(0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    repeat (20) @(negedge clk);
    chk("bad slave req_ready", 32'(o_ready[0]), 32'd0);
    chk("bad slave pselx",     32'(o_psel[0]),  32'd0);
    chk("bad slave pready",    32'(o_prdy[0]),  32'd0);
    #1 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;

    // Zero-wait slaves on dut1
    t_valid[1] = 1'b1; t_slave[1] = 1'b1; t_write[1] = 1'b1; t_wdata[1] = 32'hCAFE_0002;
    @(posedge clk); #2 t_valid[1] = 1'b0;
    @(negedge clk);
    chk("w0 setup pselx",    32'(o_psel[1]), 32'd2);
    @(negedge clk);
    chk("w0 access penable", 32'(o_pen[1]),  32'd1);
    chk("w0 access pready",  32'(o_prdy[1]), 32'd1);
    @(negedge clk);
    chk("w0 rsp_valid",      32'(o_rv[1]),   32'd1);
    issue(1, 1'b0, 1'b1, 32'h0000_0003);
    wait_rsp(1, "w0 wr s0", n);
    issue(1, 1'b1, 1'b0, 32'h0);
    wait_rsp(1, "w0 rd s1", n);
    chk("w0 rd s1 rdata",   o_rd[1], 32'hCAFE_0002);
    chk("w0 rd s1 latency", 32'(n),  32'd3);
    issue(1, 1'b0, 1'b0, 32'h0);
    wait_rsp(1, "w0 rd s0", n);
    chk("w0 rd s0 rdata",   o_rd[1], 32'h0000_0003);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
